// File: rtl/ram_port_sequencer.sv
// Request sequencer in front of a single-port RAM with fixed read/write latency.
// Registers the RAM port, tracks in-flight reads in a valid shift register and
// returns read data in order through a first-word-fall-through response FIFO.
// Requests are credit-gated so the FIFO can never overflow. A read is stalled
// while a recent write to the same address is still settling inside the RAM.
module ram_port_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } ram_req_t;

  logic                                 rdy_en_q;
  logic                                 hazard;
  logic                                 accept, rd_acc, wr_acc, push, pop;
  logic [CW-1:0]                        fifo_cnt_q, rd_infl_q;
  logic [CW:0]                          credit_used;
  logic [READ_LATENCY:0]                rd_vld_q;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_q;
  logic [PW-1:0]                        wptr_q, rptr_q;
  ram_req_t                             ram_q;

  // Credit covers both reads still inside the RAM and data parked in the FIFO,
  // so every accepted read is guaranteed a slot when its data arrives.
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, rd_infl_q};
  assign o_req_ready = rdy_en_q && (credit_used < (CW+1)'(FIFO_DEPTH)) && !hazard;
  assign accept      = i_req_valid && o_req_ready;
  assign rd_acc      = accept && !i_req_we;
  assign wr_acc      = accept && i_req_we;
  assign push        = rd_vld_q[READ_LATENCY];
  assign o_rsp_valid = (fifo_cnt_q != '0);
  assign pop         = o_rsp_valid && i_rsp_ready;
  assign o_rsp_data  = o_rsp_valid ? fifo_q[rptr_q] : '0;
  assign o_ram_en    = ram_q.en;
  assign o_ram_we    = ram_q.we;
  assign o_ram_addr  = ram_q.addr;
  assign o_ram_din   = ram_q.din;

  // Hazard history: addresses of writes accepted in the last WRITE_LATENCY-1 cycles.
  if (WRITE_LATENCY > 1) begin : g_haz
    localparam int HD = WRITE_LATENCY - 1;
    logic [HD-1:0]                 hv_q;
    logic [HD-1:0][ADDR_WIDTH-1:0] ha_q;

    // Shift the accepted write address down the history each cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hv_q <= '0;
        ha_q <= '0;
      end else begin
        hv_q[0] <= wr_acc;
        ha_q[0] <= i_req_addr;
        for (int i = 1; i < HD; i++) begin
          hv_q[i] <= hv_q[i-1];
          ha_q[i] <= ha_q[i-1];
        end
      end
    end

    // Only reads stall; write-after-write to the same address is ordered by the RAM
    always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HD; i++)
        if (!i_req_we && hv_q[i] && (ha_q[i] == i_req_addr)) hazard = 1'b1;
    end
  end else begin : g_nohaz
    assign hazard = 1'b0;
  end

  // Ready enable comes up one edge after reset release; RAM port is registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_en_q <= 1'b0;
      ram_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      ram_q.en <= accept;
      ram_q.we <= wr_acc;
      if (accept) begin
        ram_q.addr <= i_req_addr;
        ram_q.din  <= i_req_wdata;
      end
    end
  end

  // In-flight read tracking: valid shift register plus outstanding count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_q  <= '0;
      rd_infl_q <= '0;
    end else begin
      rd_vld_q  <= {rd_vld_q[READ_LATENCY-1:0], rd_acc};
      rd_infl_q <= rd_infl_q + CW'(rd_acc) - CW'(push);
    end
  end

  // Response FIFO storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= i_ram_dout;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // The credit scheme must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && !pop && (fifo_cnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Randomized + directed bench for ram_port_sequencer. A behavioural RAM with the
// configured latencies drives i_ram_dout; a reference model (architectural memory,
// queue of outstanding reads, last-write edge per address) predicts every output.
module tb_ram_port_sequencer;
  localparam int DW = 8, AW = 4, RL = 2, WL = 2, DEPTH = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_req_valid = 1'b0, i_req_we = 1'b0, i_rsp_ready = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0, i_ram_dout = '0;
  logic          o_req_ready, o_ram_en, o_ram_we, o_rsp_valid;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din, o_rsp_data;

  ram_port_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
                       .WRITE_LATENCY(WL), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din),
    .i_ram_dout(i_ram_dout), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data));

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge i_clk) cyc++;

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rdl [RL];
  logic          pw_v [WL];
  logic [AW-1:0] pw_a [WL];
  logic [DW-1:0] pw_d [WL];

  always @(posedge i_clk) begin
    if (pw_v[WL-1]) mem[pw_a[WL-1]] = pw_d[WL-1];
    for (int k = WL-1; k > 0; k--) begin
      pw_v[k] = pw_v[k-1]; pw_a[k] = pw_a[k-1]; pw_d[k] = pw_d[k-1];
    end
    pw_v[0] = o_ram_en && o_ram_we; pw_a[0] = o_ram_addr; pw_d[0] = o_ram_din;
    for (int k = RL-1; k > 0; k--) rdl[k] = rdl[k-1];
    rdl[0] = (o_ram_en && !o_ram_we) ? mem[o_ram_addr] : DW'($urandom);
    i_ram_dout <= rdl[RL-1];
  end

  // ---------------- reference model ----------------
  typedef struct { logic [DW-1:0] data; int pedge; } exp_t;
  exp_t          exp_q [$];
  logic [DW-1:0] rmem [16];
  int            last_wr [16];
  logic          live;
  logic          p_acc = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_din = '0;

  // ready may only be seen after an edge with reset released
  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) live <= 1'b0; else live <= 1'b1;

  always @(negedge i_clk) begin
    logic ev, haz;
    if (!i_rst_n) begin
      chk("rst_ready", o_req_ready, 0); chk("rst_ram_en", o_ram_en, 0);
      chk("rst_ram_we", o_ram_we, 0);   chk("rst_ram_addr", o_ram_addr, 0);
      chk("rst_ram_din", o_ram_din, 0); chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_rsp_data", o_rsp_data, 0);
      exp_q.delete();
      for (int a = 0; a < 16; a++) last_wr[a] = -100;
      p_acc = 1'b0;
    end else begin
      chk("ram_en", o_ram_en, p_acc);
      chk("ram_we", o_ram_we, p_acc && p_we);
      if (p_acc) chk("ram_addr", o_ram_addr, p_addr);
      if (p_acc && p_we) chk("ram_din", o_ram_din, p_din);
      ev = 1'b0;
      if (exp_q.size() > 0) ev = (exp_q[0].pedge <= cyc);
      chk("rsp_valid", o_rsp_valid, ev);
      if (ev) chk("rsp_data", o_rsp_data, exp_q[0].data);
      if (!live) chk("ready_pre", o_req_ready, 0);
      else if (i_req_valid) begin
        haz = !i_req_we && ((cyc + 1 - last_wr[i_req_addr]) < WL);
        chk("ready", o_req_ready, (exp_q.size() < DEPTH) && !haz);
      end
      if (ev && i_rsp_ready) void'(exp_q.pop_front());
      p_acc = i_req_valid && o_req_ready;
      p_we = i_req_we; p_addr = i_req_addr; p_din = i_req_wdata;
      if (p_acc) begin
        if (i_req_we) begin
          rmem[i_req_addr] = i_req_wdata;
          last_wr[i_req_addr] = cyc + 1;
        end else exp_q.push_back('{rmem[i_req_addr], cyc + 2 + RL});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int acc_edge);
    logic acc, got;
    got = 1'b0; acc_edge = -1;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge i_clk); acc = i_req_valid && o_req_ready;
      @(posedge i_clk); #1;
      if (acc) begin got = 1'b1; acc_edge = cyc; end
    end
    i_req_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int e0, e1, e2, e3, e4, eup;
    logic acc;
    for (int a = 0; a < 16; a++) begin
      mem[a] = DW'(a * 37 + 5); rmem[a] = DW'(a * 37 + 5); last_wr[a] = -100;
    end
    for (int k = 0; k < WL; k++) pw_v[k] = 1'b0;
    for (int k = 0; k < RL; k++) rdl[k] = '0;

    #1 i_rst_n = 1'b0;
    idle(3);
    i_rst_n = 1'b1;
    @(negedge i_clk); chk("rdy_before_edge", o_req_ready, 0);
    @(negedge i_clk); chk("rdy_rise", o_req_ready, 1);
    @(posedge i_clk); #1;

    // write then read same address: read held one cycle
    send(1'b1, 4'd3, 8'hA5, e0);
    send(1'b0, 4'd3, 8'h00, e1);
    chk("haz_gap", e1 - e0, WL);
    for (int k = 0; k <= RL; k++) begin @(negedge i_clk); chk("rd_lat_quiet", o_rsp_valid, 0); end
    @(negedge i_clk); chk("rd_lat_valid", o_rsp_valid, 1); chk("rd_lat_data", o_rsp_data, 8'hA5);
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    idle(4);

    // write-after-write to the same address does not stall
    send(1'b1, 4'd5, 8'h11, e0);
    send(1'b1, 4'd5, 8'h22, e1);
    chk("waw_nostall", e1 - e0, 1);
    send(1'b0, 4'd5, 8'h00, e2);
    idle(8);
    chk("waw_drained", exp_q.size(), 0);

    // fill FIFO with back-to-back reads, fifth held until consumer drains
    i_rsp_ready = 1'b0;
    send(1'b0, 4'd0, 8'h0, e0); send(1'b0, 4'd1, 8'h0, e1);
    send(1'b0, 4'd2, 8'h0, e2); send(1'b0, 4'd3, 8'h0, e3);
    chk("b2b_reads", e3 - e0, 3);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 4'd4;
    repeat (6) begin @(negedge i_clk); chk("fifth_held", o_req_ready, 0); @(posedge i_clk); #1; end
    i_rsp_ready = 1'b1; eup = cyc;
    send(1'b0, 4'd4, 8'h0, e4);
    chk("fifth_after_drain", e4 > eup, 1);
    idle(8);

    // continuous reads with consumer always ready, wrapping pointers several times
    for (int i = 0; i < 40; i++) send(1'b0, AW'(i), 8'h0, e0);
    idle(8);
    chk("stream_drained", exp_q.size(), 0);

    // reset with reads in flight: nothing survives
    send(1'b0, 4'd7, 8'h0, e0);
    send(1'b0, 4'd8, 8'h0, e1);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (6) begin @(negedge i_clk); chk("post_rst_quiet", o_rsp_valid, 0); end
    @(posedge i_clk); #1;

    // random traffic, small address range to provoke hazards
    for (int t = 0; t < 400; t++) begin
      @(negedge i_clk); acc = i_req_valid && o_req_ready;
      @(posedge i_clk); #1;
      i_rsp_ready = 1'($urandom_range(0, 1));
      if (acc || !i_req_valid) begin
        i_req_valid = ($urandom_range(0, 9) < 7);
        i_req_we    = ($urandom_range(0, 9) < 4);
        i_req_addr  = AW'($urandom_range(0, 3));
        i_req_wdata = DW'($urandom);
      end
    end
    i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    idle(12);
    chk("final_drained", exp_q.size(), 0);
    chk("final_rsp_idle", o_rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
